// File: rtl/ball_split_dispatcher.sv
// ball_split_dispatcher
// Turns a collision hit into a retire strobe for the hit ball followed by
// two child-ball load commands. Each child goes into the lowest free slot.
// A child that finds no free slot is counted in dropCount, which saturates.

module ball_split_dispatcher #(
    parameter int NUM_SLOTS     = 8,
    parameter int X_OFFSET      = 16,
    parameter int X_MAX         = 639,
    parameter int SPLIT_X_SPEED = 64,
    parameter int SPLIT_Y_SPEED = -256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hit,
    input  logic [$clog2(NUM_SLOTS)-1:0] hitSlot,
    input  logic [10:0]                  hitX,
    input  logic [10:0]                  hitY,
    input  logic [1:0]                   hitSize,
    input  logic [NUM_SLOTS-1:0]         slotActive,
    output logic                         hitReady,
    output logic [NUM_SLOTS-1:0]         killSlot,
    output logic [NUM_SLOTS-1:0]         loadSlot,
    output logic [10:0]                  ballInitialX,
    output logic [10:0]                  ballInitialY,
    output shortint                      ballInitialXSpeed,
    output shortint                      ballInitialYSpeed,
    output logic [1:0]                   ballInitialSize,
    output logic [7:0]                   dropCount
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam shortint LEFT_XSPEED  = shortint'(-SPLIT_X_SPEED);
    localparam shortint RIGHT_XSPEED = shortint'(SPLIT_X_SPEED);
    localparam shortint CHILD_YSPEED = shortint'(SPLIT_Y_SPEED);

    typedef enum logic [1:0] {
        IDLE,
        KILL,
        LEFT,
        RIGHT
    } state_t;

    state_t state;

    logic [SW-1:0]        capSlot;
    logic [10:0]          capX;
    logic [10:0]          capY;
    logic [1:0]           capSize;
    logic [SW-1:0]        leftSlot;
    logic                 leftValid;

    logic [NUM_SLOTS-1:0] freeMask;
    logic [NUM_SLOTS-1:0] rightMask;
    logic                 leftFound;
    logic [SW-1:0]        leftIdx;
    logic                 rightFound;
    logic [SW-1:0]        rightIdx;
    logic [11:0]          xWide;
    logic [11:0]          rightSum;
    logic [10:0]          leftX;
    logic [10:0]          rightX;

    assign hitReady = (state == IDLE);

    // Free slots: the hit ball's slot counts as free even before slotActive drops it.
    always_comb begin
        freeMask          = ~slotActive;
        freeMask[capSlot] = 1'b1;
        rightMask         = freeMask;
        if (leftValid) begin
            rightMask[leftSlot] = 1'b0;
        end
    end

    // Lowest-index free slot for each child; scanning downward leaves the lowest hit last.
    always_comb begin
        leftFound  = 1'b0;
        leftIdx    = '0;
        rightFound = 1'b0;
        rightIdx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (freeMask[i]) begin
                leftFound = 1'b1;
                leftIdx   = SW'(i);
            end
            if (rightMask[i]) begin
                rightFound = 1'b1;
                rightIdx   = SW'(i);
            end
        end
    end

    // Child X positions, using 12-bit sums so the clamps see underflow and overflow.
    always_comb begin
        xWide    = {1'b0, capX};
        rightSum = xWide + 12'(X_OFFSET);
        leftX    = (xWide < 12'(X_OFFSET)) ? 11'd0 : 11'(xWide - 12'(X_OFFSET));
        rightX   = (rightSum > 12'(X_MAX)) ? 11'(X_MAX) : rightSum[10:0];
    end

    // Split sequencer: capture the hit, retire it, then load the left and right children.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            capSlot           <= '0;
            capX              <= '0;
            capY              <= '0;
            capSize           <= '0;
            leftSlot          <= '0;
            leftValid         <= 1'b0;
            killSlot          <= '0;
            loadSlot          <= '0;
            ballInitialX      <= '0;
            ballInitialY      <= '0;
            ballInitialXSpeed <= '0;
            ballInitialYSpeed <= '0;
            ballInitialSize   <= '0;
            dropCount         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    killSlot <= '0;
                    loadSlot <= '0;
                    if (hit) begin
                        capSlot  <= hitSlot;
                        capX     <= hitX;
                        capY     <= hitY;
                        capSize  <= hitSize;
                        killSlot <= NUM_SLOTS'(1) << hitSlot;
                        state    <= KILL;
                    end
                end
                KILL: begin
                    killSlot <= '0;
                    if (capSize == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        if (leftFound) begin
                            loadSlot          <= NUM_SLOTS'(1) << leftIdx;
                            leftSlot          <= leftIdx;
                            leftValid         <= 1'b1;
                            ballInitialX      <= leftX;
                            ballInitialY      <= capY;
                            ballInitialXSpeed <= LEFT_XSPEED;
                            ballInitialYSpeed <= CHILD_YSPEED;
                            ballInitialSize   <= capSize - 2'd1;
                        end else begin
                            loadSlot  <= '0;
                            leftValid <= 1'b0;
                            if (dropCount != 8'hFF) begin
                                dropCount <= dropCount + 8'd1;
                            end
                        end
                        state <= LEFT;
                    end
                end
                LEFT: begin
                    if (rightFound) begin
                        loadSlot          <= NUM_SLOTS'(1) << rightIdx;
                        ballInitialX      <= rightX;
                        ballInitialY      <= capY;
                        ballInitialXSpeed <= RIGHT_XSPEED;
                        ballInitialYSpeed <= CHILD_YSPEED;
                        ballInitialSize   <= capSize - 2'd1;
                    end else begin
                        loadSlot <= '0;
                        if (dropCount != 8'hFF) begin
                            dropCount <= dropCount + 8'd1;
                        end
                    end
                    state <= RIGHT;
                end
                RIGHT: begin
                    loadSlot  <= '0;
                    leftValid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
